// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: drives the IMEM word address, queues
// {pc, instr} pairs in a prefetch FIFO for decode, services PC redirects
// and shares the single IMEM read port with a debug read requester.
module ifetch_ctrl #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [29:0]              imem_addr,
  input  logic [31:0]              imem_instr,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  input  logic                     dbg_req,
  input  logic [29:0]              dbg_addr,
  output logic                     dbg_ack,
  output logic [31:0]              dbg_data,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    ARB_FETCH   = 1'b0,
    ARB_DBG_ACK = 1'b1
  } arb_state_e;

  arb_state_e       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [31:0]      dbg_data_q;
  logic [31:0]      mem_instr_q [DEPTH];
  logic [31:0]      mem_pc_q    [DEPTH];

  logic             dbg_gnt;
  logic             push;
  logic             pop;
  logic             unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Arbiter: debug wins in FETCH, the following cycle is the ack slot.
  always_comb begin
    state_d = state_q;
    dbg_gnt = 1'b0;
    dbg_ack = 1'b0;
    case (state_q)
      ARB_FETCH: begin
        dbg_gnt = dbg_req;
        if (dbg_req) state_d = ARB_DBG_ACK;
      end
      ARB_DBG_ACK: begin
        dbg_ack = 1'b1;
        state_d = ARB_FETCH;
      end
      default: state_d = ARB_FETCH;
    endcase
  end

  // IMEM port mux and FIFO handshake decode.
  always_comb begin
    imem_addr  = dbg_gnt ? dbg_addr : fetch_pc_q[31:2];
    push       = !dbg_gnt && !redirect_valid && (count_q < CW'(DEPTH));
    out_valid  = (count_q != '0) && !redirect_valid;
    pop        = out_valid && out_ready;
    out_instr  = mem_instr_q[rd_ptr_q];
    out_pc     = mem_pc_q[rd_ptr_q];
    dbg_data   = dbg_data_q;
    fifo_count = count_q;
  end

  // Next fetch PC, pointers and occupancy; redirect overrides push/pop.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_FETCH;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (dbg_gnt) dbg_data_q <= imem_instr;
    end
  end

  // Prefetch FIFO storage, written on push at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
    end else if (push) begin
      mem_instr_q[wr_ptr_q] <= imem_instr;
      mem_pc_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_ifetch_ctrl;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        dbg_req = 1'b0;
  logic [29:0] dbg_addr = '0;
  logic        dbg_ack;
  logic [31:0] dbg_data;
  logic [2:0]  fifo_count;

  ifetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_ack(dbg_ack), .dbg_data(dbg_data),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // IMEM contents: word k holds 0x1000_0000 + k.
  assign imem_instr = 32'h1000_0000 + {2'b00, imem_addr};

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of PCs in the prefetch buffer.
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_ack;
  logic [31:0] m_dbg_data;

  function automatic logic [31:0] word_of(input logic [31:0] byte_addr);
    return 32'h1000_0000 + {2'b00, byte_addr[31:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc       = RESET_PC;
    m_ack      = 1'b0;
    m_dbg_data = '0;
  endtask

  // Apply inputs just after the falling edge and compare all outputs.
  task automatic drive(input bit rv, input logic [31:0] rpc, input bit rdy,
                       input bit dq, input logic [29:0] da);
    bit gnt;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    dbg_req        = dq;
    dbg_addr       = da;
    #1;
    gnt = dq && !m_ack;
    chk("imem_addr", {2'b00, imem_addr}, gnt ? {2'b00, da} : {2'b00, m_pc[31:2]});
    chk("out_valid", {31'd0, out_valid}, {31'd0, (m_q.size() != 0) && !rv});
    chk("fifo_count", {29'd0, fifo_count}, m_q.size());
    if (m_q.size() != 0) begin
      chk("out_pc", out_pc, m_q[0]);
      chk("out_instr", out_instr, word_of(m_q[0]));
    end
    chk("dbg_ack", {31'd0, dbg_ack}, {31'd0, m_ack});
    chk("dbg_data", dbg_data, m_dbg_data);
  endtask

  // Advance the model by one cycle and move to the next falling edge.
  task automatic tick();
    bit gnt;
    int sz;
    gnt = dbg_req && !m_ack;
    sz  = m_q.size();
    if (gnt) m_dbg_data = word_of({dbg_addr, 2'b00});
    if (redirect_valid) begin
      m_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (sz > 0 && out_ready) void'(m_q.pop_front());
      if (!gnt && sz < DEPTH) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    m_ack = gnt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, rdy, 1'b0, '0);
      tick();
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    // Reset state.
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_imem_addr", {2'b00, imem_addr}, {2'b00, RESET_PC[31:2]});
    rst_n = 1'b1;

    // Sequential fetch: first valid one cycle after first edge.
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("first_cycle_valid", {31'd0, out_valid}, 32'd0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("seq_first_pc", out_pc, 32'h0);
    chk("seq_first_instr", out_instr, 32'h1000_0000);
    tick();
    run(8, 1'b1);

    // Redirect back to 0, then backpressure for 10 cycles.
    drive(1'b1, 32'h0, 1'b1, 1'b0, '0);
    tick();
    run(10, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("bp_full", {29'd0, fifo_count}, 32'd4);
    chk("bp_addr_frozen", {2'b00, imem_addr}, 32'd4);
    chk("bp_head", out_pc, 32'h0);
    tick();
    run(8, 1'b1);

    // Redirect while streaming.
    drive(1'b1, 32'h0000_0103, 1'b1, 1'b0, '0);
    chk("redir_R_valid", {31'd0, out_valid}, 32'd0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("redir_R1_count", {29'd0, fifo_count}, 32'd0);
    chk("redir_R1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("redir_R2_pc", out_pc, 32'h100);
    tick();

    // Redirect with full FIFO and out_ready high.
    run(6, 1'b0);
    drive(1'b1, 32'h0000_0400, 1'b1, 1'b0, '0);
    chk("redir_full_count", {29'd0, fifo_count}, 32'd4);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("redir_full_empty", {29'd0, fifo_count}, 32'd0);
    tick();
    run(4, 1'b1);

    // Debug read held for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b1, 30'h5);
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("dbg_data_word5", dbg_data, 32'h1000_0005);
    tick();
    run(3, 1'b1);

    // Reset mid-operation with 3 queued and a grant pending.
    drive(1'b1, 32'h0000_0200, 1'b0, 1'b0, '0);
    tick();
    run(3, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1, 30'h7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_count", {29'd0, fifo_count}, 32'd0);
    chk("arst_ack", {31'd0, dbg_ack}, 32'd0);
    chk("arst_out_pc", out_pc, 32'h0);
    chk("arst_dbg_data", dbg_data, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("arst_no_ack", {31'd0, dbg_ack}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(3, 1'b1);

    // PC wrap at the top of the address space.
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, '0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("wrap_pc1", out_pc, 32'h0000_0000);
    tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 3) == 0), 30'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
